// File: rtl/clock_state_engine.sv
// clock_state_engine
// Timekeeping core for the Nixie clock. A prescaler divides the board clock
// down to a one-second tick that advances a seconds/minutes/hours state.
// A one-hot cursor with up/down pulses edits single fields. A tick that
// collides with an edit is held in tick_pending and applied later. Hours
// are stored 0..23 and shown in 12- or 24-hour form.
module clock_state_engine #(
    parameter int unsigned TICK_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode24,
    input  logic       run_en,
    input  logic       up,
    input  logic       down,
    input  logic       clear,
    input  logic [2:0] cursor,
    output logic [5:0] second,
    output logic [5:0] minute,
    output logic [5:0] hour,
    output logic       pm,
    output logic       sec_tick
);

    localparam int unsigned    PW     = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0]  P_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        FLD_NONE,
        FLD_SEC,
        FLD_MIN,
        FLD_HR
    } field_e;

    // state registers
    logic [5:0]    r_sec, r_min, r_hr;
    logic [PW-1:0] r_presc;
    logic          r_pend;
    logic          r_tick;

    // next-state and decode wires
    logic [5:0]    w_sec_nx, w_min_nx, w_hr_nx;
    logic [PW-1:0] w_presc_nx;
    logic          w_pend_nx;
    logic          w_tick_nx;
    field_e        w_field;
    logic          w_edit;
    logic          w_tick;
    logic          w_advance;

    // per-field wrap-around increment/decrement values
    logic [5:0]    w_sec_inc, w_sec_dec;
    logic [5:0]    w_min_inc, w_min_dec;
    logic [5:0]    w_hr_inc,  w_hr_dec;

    // Decode cursor into a field select; non-one-hot values select nothing
    always_comb begin
        w_field = FLD_NONE;
        case (cursor)
            3'b001:  w_field = FLD_SEC;
            3'b010:  w_field = FLD_MIN;
            3'b100:  w_field = FLD_HR;
            default: w_field = FLD_NONE;
        endcase
        w_edit    = (up ^ down) && (w_field != FLD_NONE);
        w_tick    = run_en && (r_presc == P_LAST);
        w_advance = w_tick || r_pend;
    end

    // Wrap arithmetic within each field, shared by edits and advance
    always_comb begin
        w_sec_inc = (r_sec == 6'd59) ? 6'd0  : r_sec + 6'd1;
        w_sec_dec = (r_sec == 6'd0)  ? 6'd59 : r_sec - 6'd1;
        w_min_inc = (r_min == 6'd59) ? 6'd0  : r_min + 6'd1;
        w_min_dec = (r_min == 6'd0)  ? 6'd59 : r_min - 6'd1;
        w_hr_inc  = (r_hr  == 6'd23) ? 6'd0  : r_hr  + 6'd1;
        w_hr_dec  = (r_hr  == 6'd0)  ? 6'd23 : r_hr  - 6'd1;
    end

    // Next state: clear beats edit, edit beats advance (advance deferred)
    always_comb begin
        w_sec_nx   = r_sec;
        w_min_nx   = r_min;
        w_hr_nx    = r_hr;
        w_pend_nx  = r_pend;
        w_tick_nx  = 1'b0;
        w_presc_nx = r_presc;
        if (run_en) begin
            w_presc_nx = w_tick ? '0 : r_presc + PW'(1);
        end

        if (clear) begin
            w_sec_nx   = '0;
            w_min_nx   = '0;
            w_hr_nx    = '0;
            w_presc_nx = '0;
            w_pend_nx  = 1'b0;
        end else if (w_edit) begin
            case (w_field)
                FLD_SEC: begin
                    w_sec_nx   = up ? w_sec_inc : w_sec_dec;
                    w_presc_nx = '0;
                end
                FLD_MIN: w_min_nx = up ? w_min_inc : w_min_dec;
                FLD_HR:  w_hr_nx  = up ? w_hr_inc  : w_hr_dec;
                default: ;
            endcase
            // a tick landing on an edit cycle is kept for the next free edge
            w_pend_nx = r_pend | w_tick;
        end else if (w_advance) begin
            w_sec_nx  = w_sec_inc;
            if (r_sec == 6'd59) begin
                w_min_nx = w_min_inc;
                if (r_min == 6'd59) begin
                    w_hr_nx = w_hr_inc;
                end
            end
            w_pend_nx = 1'b0;
            w_tick_nx = 1'b1;
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sec   <= '0;
            r_min   <= '0;
            r_hr    <= '0;
            r_presc <= '0;
            r_pend  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_sec   <= w_sec_nx;
            r_min   <= w_min_nx;
            r_hr    <= w_hr_nx;
            r_presc <= w_presc_nx;
            r_pend  <= w_pend_nx;
            r_tick  <= w_tick_nx;
        end
    end

    // Display formatting: 24-hour passthrough or 12-hour with 0 shown as 12
    always_comb begin
        second   = r_sec;
        minute   = r_min;
        sec_tick = r_tick;
        pm       = (r_hr >= 6'd12);
        if (mode24) begin
            hour = r_hr;
        end else if (r_hr == 6'd0) begin
            hour = 6'd12;
        end else if (r_hr > 6'd12) begin
            hour = r_hr - 6'd12;
        end else begin
            hour = r_hr;
        end
    end

endmodule

// File: tb/tb_clock_state_engine.sv
// Bench for clock_state_engine with TICK_CYCLES=4: directed scenarios then
// random traffic, all checked against a seconds-of-day reference model.
module tb_clock_state_engine;

    localparam int TC = 4;

    logic       clk = 1'b0;
    logic       reset, mode24, run_en, up, down, clear;
    logic [2:0] cursor;
    logic [5:0] second, minute, hour;
    logic       pm, sec_tick;

    int checks = 0;
    int errors = 0;

    // reference model: time as seconds of day, prescaler phase, pending flag
    int m_t, m_p, m_pend, m_stk;

    clock_state_engine #(.TICK_CYCLES(TC)) dut (
        .clk(clk), .reset(reset), .mode24(mode24), .run_en(run_en),
        .up(up), .down(down), .clear(clear), .cursor(cursor),
        .second(second), .minute(minute), .hour(hour), .pm(pm),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_hour(input int t, input logic m24);
        int h;
        h = t / 3600;
        if (m24) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    task automatic check_all(input string tag);
        compare({tag, "_sec"},  int'(second),   m_t % 60);
        compare({tag, "_min"},  int'(minute),   (m_t / 60) % 60);
        compare({tag, "_hour"}, int'(hour),     exp_hour(m_t, mode24));
        compare({tag, "_pm"},   int'(pm),       (m_t / 3600 >= 12) ? 1 : 0);
        compare({tag, "_tick"}, int'(sec_tick), m_stk);
    endtask

    task automatic model_reset();
        m_t = 0; m_p = 0; m_pend = 0; m_stk = 0;
    endtask

    task automatic model_edge(input logic u, input logic d, input logic c,
                              input logic [2:0] cur, input logic run);
        int  h, mi, s, dir;
        bit  tick, edit;
        tick = run && (m_p == TC - 1);
        edit = (u != d) && (cur == 3'b001 || cur == 3'b010 || cur == 3'b100);
        m_stk = 0;
        if (c) begin
            m_t = 0; m_p = 0; m_pend = 0;
            return;
        end
        if (run) m_p = (m_p + 1) % TC;
        if (edit) begin
            h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
            dir = u ? 1 : -1;
            if (cur == 3'b001) begin s = (s + dir + 60) % 60; m_p = 0; end
            if (cur == 3'b010) mi = (mi + dir + 60) % 60;
            if (cur == 3'b100) h = (h + dir + 24) % 24;
            m_t = h * 3600 + mi * 60 + s;
            if (tick) m_pend = 1;
        end else if (tick || m_pend) begin
            m_t = (m_t + 1) % 86400;
            m_pend = 0;
            m_stk = 1;
        end
    endtask

    // one clock: drive at negedge, model at posedge, check 1 time unit later
    task automatic step(input string tag, input logic u, input logic d,
                        input logic c, input logic [2:0] cur, input logic run);
        up = u; down = d; clear = c; cursor = cur; run_en = run;
        @(posedge clk);
        model_edge(u, d, c, cur, run);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n, input logic run);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 3'b000, run);
    endtask

    task automatic edit_n(input string tag, input logic [2:0] cur,
                          input logic u, input int n);
        for (int i = 0; i < n; i++) step(tag, u, ~u, 1'b0, cur, 1'b0);
    endtask

    // asynchronous reset asserted between edges, checked before next edge
    task automatic async_reset(input string tag);
        logic m24_save;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        m24_save = mode24;
        mode24 = 1'b0;
        #1;
        compare({tag, "_h12"}, int'(hour), 12);
        compare({tag, "_pm0"}, int'(pm), 0);
        mode24 = m24_save;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        logic u, d, c, run;
        logic [2:0] cur;
        int r;

        reset = 1'b1; mode24 = 1'b1; run_en = 1'b0;
        up = 1'b0; down = 1'b0; clear = 1'b0; cursor = 3'b000;
        model_reset();
        @(negedge clk);
        #1 check_all("rst0");
        compare("rst0_hour24", int'(hour), 0);
        @(negedge clk);
        reset = 1'b0;

        // 10:20:30 then asynchronous reset mid-run
        edit_n("set", 3'b100, 1'b1, 10);
        edit_n("set", 3'b010, 1'b1, 20);
        edit_n("set", 3'b001, 1'b1, 30);
        compare("set_10h", int'(hour), 10);
        idle("run", 3, 1'b1);
        async_reset("arst");

        // rollover 23:59:58 -> 00:00:00
        edit_n("roll_set", 3'b100, 1'b0, 1);
        edit_n("roll_set", 3'b010, 1'b0, 1);
        edit_n("roll_set", 3'b001, 1'b0, 2);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step("roll", 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
            if (sec_tick) n++;
            if (i == 3) compare("roll_59", int'(second), 59);
        end
        compare("roll_ticks", n, 2);
        compare("roll_zero_h", int'(hour), 0);
        compare("roll_zero_s", int'(second), 0);
        idle("frozen", 20, 1'b0);
        compare("frozen_s", int'(second), 0);

        // minute edit wrap without carry
        step("mdown", 1'b0, 1'b1, 1'b0, 3'b010, 1'b0);
        compare("mdown_59", int'(minute), 59);
        step("mup", 1'b1, 1'b0, 1'b0, 3'b010, 1'b0);
        compare("mup_0", int'(minute), 0);
        compare("mup_h", int'(hour), 0);

        // 12-hour formatting
        mode24 = 1'b0;
        #1 compare("f_h0", int'(hour), 12);
        edit_n("f12", 3'b100, 1'b1, 12);
        compare("f_h12", int'(hour), 12);
        compare("f_pm12", int'(pm), 1);
        edit_n("f13", 3'b100, 1'b1, 1);
        compare("f_h13", int'(hour), 1);
        mode24 = 1'b1;
        #1 compare("f_m24", int'(hour), 13);

        // edit/tick collision at 05:10:20
        step("cclr", 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
        edit_n("cset", 3'b100, 1'b1, 5);
        edit_n("cset", 3'b010, 1'b1, 10);
        edit_n("cset", 3'b001, 1'b1, 20);
        idle("cwait", 3, 1'b1);
        step("coll", 1'b1, 1'b0, 1'b0, 3'b010, 1'b1);
        compare("coll_m", int'(minute), 11);
        compare("coll_s", int'(second), 20);
        step("defer", 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        compare("defer_s", int'(second), 21);
        compare("defer_tick", int'(sec_tick), 1);

        // invalid edits
        step("both", 1'b1, 1'b1, 1'b0, 3'b001, 1'b1);
        step("badcur", 1'b1, 1'b0, 1'b0, 3'b011, 1'b1);

        // clear with an edit and a pending tick
        for (int i = 0; i < TC && m_p != TC - 1; i++) idle("pwait", 1, 1'b1);
        step("pend", 1'b1, 1'b0, 1'b0, 3'b010, 1'b1);
        step("clrp", 1'b1, 1'b0, 1'b1, 3'b010, 1'b1);
        compare("clrp_s", int'(second), 0);
        compare("clrp_tick", int'(sec_tick), 0);
        n = 0;
        for (int i = 0; i < TC - 1; i++) begin
            step("clrp_idle", 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
            if (sec_tick) n++;
        end
        compare("clrp_quiet", n, 0);
        step("clrp_next", 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        compare("clrp_next_tick", int'(sec_tick), 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            r   = $urandom_range(0, 99);
            u   = (r < 15) || (r >= 30 && r < 33);
            d   = (r >= 15 && r < 33);
            c   = (r == 99);
            cur = 3'($urandom_range(0, 7));
            run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 31) == 0) mode24 = ~mode24;
            if ($urandom_range(0, 249) == 0) async_reset("rnd_rst");
            step("rnd", u, d, c, cur, run);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
